// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load/fetch controller.
// The word constants describe what the attached memory returns for unwritten and out-of-range words.
package imem_pkg;

  localparam int MEM_SIZE_DEF = 1024;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 32;

  localparam logic [31:0] DEFAULT_WORD = 32'h0BADCAFE;
  localparam logic [31:0] OOB_WORD     = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Arbiter for the instruction memory's single port: streams a program image in during LOAD,
// otherwise forwards fetch PCs and flags the registered read data as valid one cycle later.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              fvalid_reg;
  logic              fetch_accept;

  logic [ADDR_W:0]   load_end;
  logic              range_bad;
  logic              len_zero;
  logic [ADDR_W-1:0] idx_inc;

  // One extra bit so base+len cannot wrap past the memory limit.
  assign load_end  = {1'b0, load_base} + {1'b0, load_len};
  assign range_bad = load_end > MEM_LIMIT;
  assign len_zero  = (load_len == '0);
  assign idx_inc   = idx_reg + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      base_reg   <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      fvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      base_reg   <= base_next;
      len_reg    <= len_next;
      idx_reg    <= idx_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      fvalid_reg <= fetch_accept;
    end
  end

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    s_ready      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fetch_stall  = 1'b0;
    fetch_accept = 1'b0;

    case (state_reg)
      IDLE, RUN: begin
        if (load_start) begin
          // A colliding fetch loses; the fetch unit holds its request.
          fetch_stall = fetch_req;
          if (len_zero) begin
            done_next  = 1'b1;
            err_next   = 1'b0;
            state_next = RUN;
          end else if (range_bad) begin
            err_next = 1'b1;
          end else begin
            base_next  = load_base;
            len_next   = load_len;
            idx_next   = '0;
            err_next   = 1'b0;
            state_next = LOAD;
          end
        end else if (fetch_req) begin
          fetch_accept = 1'b1;
          mem_addr     = fetch_pc;
        end
      end

      LOAD: begin
        s_ready     = 1'b1;
        fetch_stall = fetch_req;
        mem_addr    = base_reg + idx_reg;
        if (s_valid) begin
          mem_we    = 1'b1;
          mem_wdata = s_data;
          idx_next  = idx_inc;
          if (idx_inc == len_reg) begin
            state_next = RUN;
            done_next  = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign load_busy   = (state_reg == LOAD);
  assign load_done   = done_reg;
  assign load_err    = err_reg;
  assign fetch_valid = fvalid_reg;
  assign fetch_instr = mem_rdata;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed/randomized bench for imem_load_ctrl with a behavioural memory and an expected-contents model.
module tb_imem_load_ctrl;
  import imem_pkg::*;

  localparam int MS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [31:0] load_base, load_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready, load_busy, load_done, load_err;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_stall, fetch_valid;
  logic [31:0] fetch_instr, mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:MS-1];
  logic [31:0] exp_mem [0:MS-1];

  imem_load_ctrl #(.MEM_SIZE(MS), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment: registered read, contents survive reset, output resets to zero.
  initial for (int i = 0; i < MS; i++) mem[i] = DEFAULT_WORD;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we && mem_addr < MS) mem[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= (mem_addr < MS) ? mem[mem_addr[9:0]] : OOB_WORD;
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    if (pc >= MS) return OOB_WORD;
    return exp_mem[pc[9:0]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_burst(input logic [31:0] pc0, input int n);
    for (int k = 0; k < n; k++) begin
      fetch_req = 1'b1;
      fetch_pc  = pc0 + k;
      @(negedge clk);
      check("fetch_stall", {31'b0, fetch_stall}, 32'd0);
      check("fetch_addr", mem_addr, pc0 + k);
      cyc();
      check("fetch_valid", {31'b0, fetch_valid}, 32'd1);
      check("fetch_instr", fetch_instr, exp_word(pc0 + k));
      $display("fetch pc=%0d instr=%h", pc0 + k, fetch_instr);
    end
    fetch_req = 1'b0;
    cyc();
    check("fetch_valid_drop", {31'b0, fetch_valid}, 32'd0);
  endtask

  // Loads `stop_after` words of a `len`-word image; a held fetch_req is checked for stalling.
  task automatic do_load(input logic [31:0] base, input logic [31:0] len, input int stop_after);
    int k = 0;
    int budget = 0;
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    @(negedge clk);
    check("start_we", {31'b0, mem_we}, 32'd0);
    if (fetch_req) check("start_stall", {31'b0, fetch_stall}, 32'd1);
    cyc();
    load_start = 1'b0;
    check("load_busy", {31'b0, load_busy}, 32'd1);
    check("load_err_clr", {31'b0, load_err}, 32'd0);
    while (k < stop_after && budget < 200) begin
      s_valid = (budget == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      @(negedge clk);
      check("s_ready", {31'b0, s_ready}, 32'd1);
      check("load_we", {31'b0, mem_we}, {31'b0, s_valid});
      if (fetch_req) check("load_stall", {31'b0, fetch_stall}, 32'd1);
      if (s_valid) begin
        check("load_addr", mem_addr, base + k);
        check("load_wdata", mem_wdata, s_data);
      end
      cyc();
      if (s_valid) begin
        exp_mem[(base + k) % MS] = s_data;
        $display("write addr=%0d data=%h", base + k, s_data);
        k++;
      end
      budget++;
    end
    s_valid = 1'b0;
    check("load_words", k, stop_after);
    if (stop_after == len) begin
      check("load_done", {31'b0, load_done}, 32'd1);
      check("busy_after", {31'b0, load_busy}, 32'd0);
      if (fetch_req) begin
        @(negedge clk);
        check("held_stall", {31'b0, fetch_stall}, 32'd0);
        cyc();
        fetch_req = 1'b0;
        check("held_valid", {31'b0, fetch_valid}, 32'd1);
        check("held_instr", fetch_instr, exp_word(fetch_pc));
        $display("held fetch pc=%0d instr=%h", fetch_pc, fetch_instr);
      end else begin
        cyc();
        check("done_pulse", {31'b0, load_done}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] rb, rl;
    for (int i = 0; i < MS; i++) exp_mem[i] = DEFAULT_WORD;
    reset = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    s_valid = 1'b0; s_data = '0; fetch_req = 1'b0; fetch_pc = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check("rst_busy", {31'b0, load_busy}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_err", {31'b0, load_err}, 32'd0);
    check("rst_fvalid", {31'b0, fetch_valid}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_stall", {31'b0, fetch_stall}, 32'd0);
    $display("reset state checked");

    fetch_burst(32'd5, 1);

    do_load(32'd0, 32'd4, 4);
    fetch_burst(32'd0, 4);

    // Out-of-range load: error flagged, nothing written, fetch still served.
    load_start = 1'b1; load_base = 32'd1020; load_len = 32'd8;
    @(negedge clk);
    check("err_we", {31'b0, mem_we}, 32'd0);
    cyc();
    load_start = 1'b0;
    check("err_set", {31'b0, load_err}, 32'd1);
    check("err_busy", {31'b0, load_busy}, 32'd0);
    $display("range error load base=1020 len=8 err=%0b", load_err);
    fetch_burst(32'd2, 1);
    do_load(32'd100, 32'd6, 6);
    fetch_burst(32'd100, 6);

    for (int t = 0; t < 3; t++) begin
      rb = $urandom_range(200, 900);
      rl = $urandom_range(1, 20);
      do_load(rb, rl, int'(rl));
      fetch_burst(rb, int'(rl));
    end

    // Fetch colliding with load_start is stalled and served after the load.
    fetch_req = 1'b1; fetch_pc = 32'd9;
    do_load(32'd8, 32'd3, 3);

    // Reset in the middle of a load.
    do_load(32'd40, 32'd4, 2);
    reset = 1'b1;
    #2;
    check("midrst_ready", {31'b0, s_ready}, 32'd0);
    check("midrst_busy", {31'b0, load_busy}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    $display("reset during load after 2 words");
    fetch_burst(32'd40, 4);

    // Reset in the middle of a fetch drops the pending valid.
    fetch_req = 1'b1; fetch_pc = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    fetch_req = 1'b0;
    #2;
    check("fetch_rst_valid", {31'b0, fetch_valid}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    check("fetch_rst_valid2", {31'b0, fetch_valid}, 32'd0);
    $display("reset during fetch");

    fetch_burst(32'd2000, 1);

    load_start = 1'b1; load_base = 32'd5; load_len = 32'd0;
    @(negedge clk);
    check("len0_we", {31'b0, mem_we}, 32'd0);
    cyc();
    load_start = 1'b0;
    check("len0_done", {31'b0, load_done}, 32'd1);
    check("len0_busy", {31'b0, load_busy}, 32'd0);
    cyc();
    check("len0_pulse", {31'b0, load_done}, 32'd0);
    $display("zero-length load done");
    fetch_burst(32'd5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
